// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: opcode list, NOP encoding, fetch FSM states.
// The opcode list is common with the MEM-stage condition evaluator.
package if_fetch_ctrl_pkg;

    localparam int          IR_W_DEF = 16;
    localparam int          OPC_W    = 5;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'h01;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'h02;
    localparam logic [OPC_W-1:0] OP_LD   = 5'h03;
    localparam logic [OPC_W-1:0] OP_ST   = 5'h04;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'h05;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'h06;
    localparam logic [OPC_W-1:0] OP_HALT = 5'h1F;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module if_id_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = IR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [IR_W-1:0] ir,
    input  logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] id_ir,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid
);

    // bubble takes priority; id_pc is left alone since it is meaningless without id_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ir    <= IR_W'(NOP_WORD);
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (bubble) begin
            id_ir    <= IR_W'(NOP_WORD);
            id_valid <= 1'b0;
        end else if (load) begin
            id_ir    <= ir;
            id_pc    <= pc;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF stage of the 16-bit CPU: PC register, next-PC mux, FETCH/HALT FSM and IF/ID register.
// Optional feature macro JUMP_CNT_EN adds a saturating jump_cnt output.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              IR_W     = IR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_rdata,
    output logic [IR_W-1:0] id_ir,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic            halted
`ifdef JUMP_CNT_EN
    ,
    output logic [15:0]     jump_cnt
`endif
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic            load, bubble;
    logic [OPC_W-1:0] opcode;

    assign opcode      = imem_rdata[IR_W-1 -: OPC_W];
    assign imem_addr   = pc;
    assign flush_idex  = jump;
    assign flush_exmem = jump;
    assign halted      = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Priority: jump > stall > normal. HALT word is latched but PC stays on it.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        bubble     = 1'b0;
        if (jump) begin
            pc_next    = jump_target;
            bubble     = 1'b1;
            state_next = FETCH;
        end else if (!stall) begin
            if (state == FETCH) begin
                load = 1'b1;
                if (opcode == OP_HALT) begin
                    state_next = HALT;
                end else begin
                    pc_next = pc + PC_W'(1);
                end
            end else begin
                bubble = 1'b1;
            end
        end
    end

    if_id_reg #(
        .PC_W (PC_W),
        .IR_W (IR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bubble   (bubble),
        .ir       (imem_rdata),
        .pc       (pc),
        .id_ir    (id_ir),
        .id_pc    (id_pc),
        .id_valid (id_valid)
    );

`ifdef JUMP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_cnt <= '0;
        end else if (jump && (jump_cnt != 16'hFFFF)) begin
            jump_cnt <= jump_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl; imem modelled as a combinational array.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [7:0]  jump_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] id_ir;
    logic [7:0]  id_pc;
    logic        id_valid;
    logic        flush_idex;
    logic        flush_exmem;
    logic        halted;
`ifdef JUMP_CNT_EN
    logic [15:0] jump_cnt;
`endif

    logic [15:0] imem [256];
    int          total;
    int          bad;
    int          njumps;

    localparam logic [15:0] HALT_W = 16'hF800;

    assign imem_rdata = imem[imem_addr];

    if_fetch_ctrl #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .IR_W     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump        (jump),
        .jump_target (jump_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_ir       (id_ir),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .flush_idex  (flush_idex),
        .flush_exmem (flush_exmem),
        .halted      (halted)
`ifdef JUMP_CNT_EN
        ,
        .jump_cnt    (jump_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] add_word(input int unsigned a);
        return {5'h01, 11'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) imem[i] = add_word(i);
        rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = 8'h00;
        njumps = 0;
        step(); step();
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_pc got %h want 00", imem_addr); end
        total++; if (id_ir !== 16'h0000) begin bad++; $display("FAIL reset_ir got %h want 0000", id_ir); end
        total++; if (id_valid !== 1'b0 || id_pc !== 8'h00) begin bad++; $display("FAIL reset_id got v=%b pc=%h want v=0 pc=00", id_valid, id_pc); end
        total++; if (halted !== 1'b0 || flush_idex !== 1'b0 || flush_exmem !== 1'b0) begin bad++; $display("FAIL reset_flags got h=%b fi=%b fe=%b want 0 0 0", halted, flush_idex, flush_exmem); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (imem_addr !== 8'(i + 1)) begin bad++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 8'(i + 1)); end
            total++; if (id_pc !== 8'(i) || id_valid !== 1'b1 || id_ir !== add_word(i)) begin bad++; $display("FAIL seq_id[%0d] got pc=%h v=%b ir=%h want pc=%h v=1 ir=%h", i, id_pc, id_valid, id_ir, 8'(i), add_word(i)); end
        end
    endtask

    task automatic test_stall();
        step(); // PC 4 -> 5
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_addr !== 8'h05) begin bad++; $display("FAIL stall_pc[%0d] got %h want 05", i, imem_addr); end
            total++; if (id_pc !== 8'h04 || id_ir !== add_word(4) || id_valid !== 1'b1) begin bad++; $display("FAIL stall_id[%0d] got pc=%h ir=%h v=%b want pc=04 ir=%h v=1", i, id_pc, id_ir, id_valid, add_word(4)); end
        end
        stall = 1'b0;
        step();
        total++; if (imem_addr !== 8'h06 || id_pc !== 8'h05) begin bad++; $display("FAIL stall_release got pc=%h id_pc=%h want 06 05", imem_addr, id_pc); end
    endtask

    task automatic test_jump();
        step(); step(); step(); // PC -> 9
        total++; if (imem_addr !== 8'h09) begin bad++; $display("FAIL jump_pre got %h want 09", imem_addr); end
        jump = 1'b1; jump_target = 8'h40; njumps++;
        #1;
        total++; if (flush_idex !== 1'b1 || flush_exmem !== 1'b1) begin bad++; $display("FAIL jump_flush got fi=%b fe=%b want 1 1", flush_idex, flush_exmem); end
        step();
        jump = 1'b0; jump_target = 8'hAA;
        #1;
        total++; if (imem_addr !== 8'h40 || id_valid !== 1'b0 || id_ir !== 16'h0000) begin bad++; $display("FAIL jump_redirect got pc=%h v=%b ir=%h want 40 0 0000", imem_addr, id_valid, id_ir); end
        total++; if (flush_idex !== 1'b0 || flush_exmem !== 1'b0) begin bad++; $display("FAIL jump_flush_clear got fi=%b fe=%b want 0 0", flush_idex, flush_exmem); end
        step();
        total++; if (id_pc !== 8'h40 || id_valid !== 1'b1 || imem_addr !== 8'h41) begin bad++; $display("FAIL jump_target_id got id_pc=%h v=%b pc=%h want 40 1 41", id_pc, id_valid, imem_addr); end
    endtask

    task automatic test_jump_stall();
        jump = 1'b1; stall = 1'b1; jump_target = 8'h10; njumps++;
        step();
        jump = 1'b0; stall = 1'b0;
        total++; if (imem_addr !== 8'h10 || id_valid !== 1'b0) begin bad++; $display("FAIL jump_stall got pc=%h v=%b want 10 0", imem_addr, id_valid); end
        step();
        total++; if (id_pc !== 8'h10 || id_valid !== 1'b1) begin bad++; $display("FAIL jump_stall_next got id_pc=%h v=%b want 10 1", id_pc, id_valid); end
    endtask

    task automatic test_back_to_back();
        jump = 1'b1; jump_target = 8'h30; njumps++;
        step();
        jump_target = 8'h50; njumps++;
        step();
        jump = 1'b0;
        total++; if (imem_addr !== 8'h50 || id_valid !== 1'b0) begin bad++; $display("FAIL b2b_redirect got pc=%h v=%b want 50 0", imem_addr, id_valid); end
        step();
        total++; if (id_pc !== 8'h50 || id_valid !== 1'b1) begin bad++; $display("FAIL b2b_id got id_pc=%h v=%b want 50 1", id_pc, id_valid); end
    endtask

    task automatic test_halt();
        imem[7] = HALT_W;
        jump = 1'b1; jump_target = 8'h05; njumps++;
        step();
        jump = 1'b0;
        step(); step(); step(); // fetch 5, 6, then HALT at 7
        total++; if (imem_addr !== 8'h07 || halted !== 1'b1) begin bad++; $display("FAIL halt_enter got pc=%h h=%b want 07 1", imem_addr, halted); end
        total++; if (id_ir !== HALT_W || id_pc !== 8'h07 || id_valid !== 1'b1) begin bad++; $display("FAIL halt_latched got ir=%h pc=%h v=%b want f800 07 1", id_ir, id_pc, id_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_addr !== 8'h07 || halted !== 1'b1 || id_valid !== 1'b0 || id_ir !== 16'h0000) begin bad++; $display("FAIL halt_hold[%0d] got pc=%h h=%b v=%b ir=%h want 07 1 0 0000", i, imem_addr, halted, id_valid, id_ir); end
        end
        jump = 1'b1; jump_target = 8'h20; njumps++;
        step();
        jump = 1'b0;
        total++; if (imem_addr !== 8'h20 || halted !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL halt_exit got pc=%h h=%b v=%b want 20 0 0", imem_addr, halted, id_valid); end
        step();
        total++; if (id_pc !== 8'h20 || id_valid !== 1'b1 || imem_addr !== 8'h21) begin bad++; $display("FAIL halt_resume got id_pc=%h v=%b pc=%h want 20 1 21", id_pc, id_valid, imem_addr); end
        imem[7] = add_word(7);
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 8'hFF; njumps++;
        step();
        jump = 1'b0;
        step();
        total++; if (imem_addr !== 8'h00 || id_pc !== 8'hFF || id_valid !== 1'b1) begin bad++; $display("FAIL wrap got pc=%h id_pc=%h v=%b want 00 ff 1", imem_addr, id_pc, id_valid); end
`ifdef JUMP_CNT_EN
        total++; if (jump_cnt !== 16'(njumps)) begin bad++; $display("FAIL jump_cnt got %0d want %0d", jump_cnt, njumps); end
`endif
    endtask

    task automatic test_async_reset();
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_addr !== 8'h00 || id_ir !== 16'h0000 || id_pc !== 8'h00 || id_valid !== 1'b0) begin bad++; $display("FAIL async_reset got pc=%h ir=%h id_pc=%h v=%b want 00 0000 00 0", imem_addr, id_ir, id_pc, id_valid); end
`ifdef JUMP_CNT_EN
        total++; if (jump_cnt !== 16'h0000) begin bad++; $display("FAIL async_reset_cnt got %0d want 0", jump_cnt); end
`endif
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_jump_stall();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
